// File: rtl/camera_word_packer.sv
// Packs eight raster-ordered 16-bit camera pixels into 128-bit AXI-Stream words with frame TLAST.
// Optional PACKER_STATS_EN adds saturating frame and drop counters.
module camera_word_packer #(
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned V_ACTIVE  = 720,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [15:0]   pixel_data_in,
    input  logic          pixel_valid_in,
    input  logic [10:0]   pixel_hcount_in,
    input  logic [9:0]    pixel_vcount_in,
    output logic [127:0]  m_axis_tdata,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready,
    output logic          overflow_out,
    output logic          resync_out
`ifdef PACKER_STATS_EN
    ,
    output logic [15:0]   frame_count_out,
    output logic [15:0]   drop_count_out
`endif
);

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned WORD_W = 128;
    localparam int unsigned ACC_W  = WORD_W - PIX_W;
    localparam int unsigned H_W    = 11;
    localparam int unsigned V_W    = 10;
    localparam int unsigned LANE_W = 3;
    localparam int unsigned CNT_W  = 16;

    localparam logic [H_W-1:0]    H_LAST    = H_W'(H_ACTIVE - 1);
    localparam logic [V_W-1:0]    V_LAST    = V_W'(V_ACTIVE - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(7);

    typedef enum logic {
        WAIT_SOF,
        PACK
    } state_e;

    state_e                state_q, state_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [H_W-1:0]        exp_h_q, exp_h_d;
    logic [V_W-1:0]        exp_v_q, exp_v_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  overflow_q, overflow_d;
    logic                  resync_q, resync_d;

    logic [WORD_W-1:0]     mem_q [OUT_DEPTH];
    logic [WORD_W-1:0]     mem_d [OUT_DEPTH];
    logic [OUT_DEPTH-1:0]  vld_q, vld_d;
    logic [OUT_DEPTH-1:0]  last_q, last_d;

    logic                  pop_c;
    logic                  full_c;
    logic                  sof_c;
    logic                  match_c;
    logic                  frame_end_c;
    logic                  push_c;
    logic [WORD_W-1:0]     push_word_c;
    logic                  push_last_c;
    logic                  slot_found_c;

    assign pop_c       = vld_q[0] & m_axis_tready;
    assign full_c      = vld_q[OUT_DEPTH-1];
    assign sof_c       = (pixel_hcount_in == '0) && (pixel_vcount_in == '0);
    assign match_c     = (pixel_hcount_in == exp_h_q) && (pixel_vcount_in == exp_v_q);
    assign frame_end_c = (exp_h_q == H_LAST) && (exp_v_q == V_LAST);

    // Frame alignment and lane packing
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        exp_h_d     = exp_h_q;
        exp_v_d     = exp_v_q;
        acc_d       = acc_q;
        overflow_d  = overflow_q;
        resync_d    = 1'b0;
        push_c      = 1'b0;
        push_word_c = '0;
        push_last_c = 1'b0;

        if (pixel_valid_in) begin
            unique case (state_q)
                WAIT_SOF: begin
                    if (sof_c) begin
                        acc_d[PIX_W-1:0] = pixel_data_in;
                        lane_d           = LANE_W'(1);
                        exp_h_d          = H_W'(1);
                        exp_v_d          = '0;
                        state_d          = PACK;
                    end
                end
                PACK: begin
                    if (match_c) begin
                        if (lane_q == LANE_LAST) begin
                            lane_d = '0;
                            if (full_c && !pop_c) begin
                                overflow_d = 1'b1;
                                resync_d   = 1'b1;
                                state_d    = WAIT_SOF;
                            end else begin
                                push_c      = 1'b1;
                                push_word_c = {pixel_data_in, acc_q};
                                push_last_c = frame_end_c;
                            end
                        end else begin
                            for (int unsigned k = 0; k < 7; k++) begin
                                if (lane_q == LANE_W'(k)) begin
                                    acc_d[PIX_W*k +: PIX_W] = pixel_data_in;
                                end
                            end
                            lane_d = lane_q + LANE_W'(1);
                        end
                        if (exp_h_q == H_LAST) begin
                            exp_h_d = '0;
                            exp_v_d = (exp_v_q == V_LAST) ? '0 : exp_v_q + V_W'(1);
                        end else begin
                            exp_h_d = exp_h_q + H_W'(1);
                        end
                    end else begin
                        resync_d = 1'b1;
                        // A misplaced (0,0) is taken as the start of a fresh frame
                        if (sof_c) begin
                            acc_d[PIX_W-1:0] = pixel_data_in;
                            lane_d           = LANE_W'(1);
                            exp_h_d          = H_W'(1);
                            exp_v_d          = '0;
                        end else begin
                            lane_d  = '0;
                            state_d = WAIT_SOF;
                        end
                    end
                end
                default: state_d = WAIT_SOF;
            endcase
        end
    end

    // Shift FIFO: entry 0 is the registered AXI head
    always_comb begin
        vld_d        = vld_q;
        last_d       = last_q;
        slot_found_c = 1'b0;
        for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (pop_c) begin
            for (int unsigned i = 0; i < OUT_DEPTH - 1; i++) begin
                mem_d[i]  = mem_q[i+1];
                vld_d[i]  = vld_q[i+1];
                last_d[i] = last_q[i+1];
            end
            mem_d[OUT_DEPTH-1]  = '0;
            vld_d[OUT_DEPTH-1]  = 1'b0;
            last_d[OUT_DEPTH-1] = 1'b0;
        end

        if (push_c) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                if (!slot_found_c && !vld_d[i]) begin
                    mem_d[i]     = push_word_c;
                    vld_d[i]     = 1'b1;
                    last_d[i]    = push_last_c;
                    slot_found_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= WAIT_SOF;
            lane_q     <= '0;
            exp_h_q    <= '0;
            exp_v_q    <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
            resync_q   <= 1'b0;
            vld_q      <= '0;
            last_q     <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            exp_h_q    <= exp_h_d;
            exp_v_q    <= exp_v_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
            resync_q   <= resync_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign m_axis_tdata  = mem_q[0];
    assign m_axis_tvalid = vld_q[0];
    assign m_axis_tlast  = last_q[0];
    assign overflow_out  = overflow_q;
    assign resync_out    = resync_q;

`ifdef PACKER_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating statistics
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (pop_c && last_q[0] && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (resync_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_count_out = frame_cnt_q;
    assign drop_count_out  = drop_cnt_q;
`endif

endmodule
